// File: rtl/prime_pkg.sv
// Shared definitions for the prime stepper: FSM encoding, width helpers and seed constants.
package prime_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StNext,
        StDiv,
        StWait
    } state_e;

    localparam int unsigned DEFAULT_WIDTH_LOG = 4;
    localparam int unsigned FIRST_PRIME       = 2;
    localparam int unsigned FIRST_ODD         = 3;

    function automatic int unsigned width_of(input int unsigned width_log);
        return 32'd1 << width_log;
    endfunction

    function automatic int unsigned hi_of(input int unsigned width_log);
        return width_of(width_log) - 1;
    endfunction

    function automatic longint unsigned max_of(input int unsigned width_log);
        return (64'd1 << width_of(width_log)) - 64'd1;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider: one quotient bit per cycle, done pulses W cycles
// after start. Divide-by-zero results are meaningless.
module seq_divider #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [W-1:0] src_rem, src_quot, src_div;
    logic [W:0]   shifted, diff;
    logic         fits;

    // The start cycle already performs the first step, so W steps end on the W-th edge.
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_quot = start ? dividend : quot_q;
        src_div  = start ? divisor : div_q;
        shifted  = {src_rem, src_quot[W-1]};
        diff     = shifted - {1'b0, src_div};
        fits     = shifted >= {1'b0, src_div};

        rem_d  = rem_q;
        quot_d = quot_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start || busy_q) begin
            rem_d  = fits ? diff[W-1:0] : shifted[W-1:0];
            quot_d = {src_quot[W-2:0], fits};
            div_d  = src_div;
            if (start) begin
                cnt_d  = CW'(W - 1);
                busy_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;

endmodule

// File: rtl/prime_stepper.sv
// Go/ready responder that steps to the next prime by odd-only trial division,
// raising a sticky error once no further prime fits in W bits.
module prime_stepper
    import prime_pkg::*;
#(
    parameter int unsigned WIDTH_LOG = DEFAULT_WIDTH_LOG,
    localparam int unsigned W = 1 << WIDTH_LOG
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    output logic         ready,
    output logic         error,
    output logic [W-1:0] res
);

    localparam logic [W-1:0] PRIME_SEED = W'(FIRST_PRIME);
    localparam logic [W-1:0] ODD_SEED   = W'(FIRST_ODD);
    localparam logic [W-1:0] STEP_W     = W'(2);
    localparam logic [W:0]   STEP_W1    = (W + 1)'(2);

    state_e       state_q, state_d;
    logic [W-1:0] res_q, res_d;
    logic [W-1:0] cand_q, cand_d;
    logic [W-1:0] d_q, d_d;
    logic         ready_q, ready_d;
    logic         error_q, error_d;

    logic         div_start, div_done;
    logic [W-1:0] div_quot, div_rem;
    logic [W:0]   sum;

    seq_divider #(
        .W(W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (cand_q),
        .divisor  (d_q),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        cand_d    = cand_q;
        d_d       = d_q;
        ready_d   = ready_q;
        error_d   = error_q;
        div_start = 1'b0;
        sum       = {1'b0, cand_q} + STEP_W1;

        unique case (state_q)
            StInit: begin
                res_d   = PRIME_SEED;
                ready_d = 1'b1;
                state_d = StIdle;
            end
            StIdle: begin
                if (go && !error_q) begin
                    ready_d = 1'b0;
                    cand_d  = res_q;
                    state_d = StNext;
                end
            end
            StNext: begin
                if (cand_q == PRIME_SEED) begin
                    cand_d  = ODD_SEED;
                    d_d     = ODD_SEED;
                    state_d = StDiv;
                end else if (sum[W]) begin
                    error_d = 1'b1;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cand_d  = sum[W-1:0];
                    d_d     = ODD_SEED;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                div_start = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                // q < d means every divisor up to sqrt(cand) has been tried.
                if (div_done) begin
                    if (div_quot < d_q) begin
                        res_d   = cand_q;
                        ready_d = 1'b1;
                        state_d = StIdle;
                    end else if (div_rem == '0) begin
                        state_d = StNext;
                    end else begin
                        d_d     = d_q + STEP_W;
                        state_d = StDiv;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            res_q   <= '0;
            cand_q  <= '0;
            d_q     <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cand_q  <= cand_d;
            d_q     <= d_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign ready = ready_q;
    assign error = error_q;
    assign res   = res_q;

endmodule

// File: tb/tb_prime_stepper.sv
// Self-checking bench: divider unit vectors, 16-bit stepper sequences and a full 8-bit sweep
// up to the overflow point, all against an arithmetic prime model.
module tb_prime_stepper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst16_n, go16, ready16, error16;
    logic [15:0] res16;
    logic        rst8_n, go8, ready8, error8;
    logic [7:0]  res8;
    logic        rstd_n, dv_start, dv_done;
    logic [15:0] dv_a, dv_b, dv_q, dv_r;

    prime_stepper #(.WIDTH_LOG(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst16_n),
        .go    (go16),
        .ready (ready16),
        .error (error16),
        .res   (res16)
    );

    prime_stepper #(.WIDTH_LOG(3)) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .go    (go8),
        .ready (ready8),
        .error (error8),
        .res   (res8)
    );

    seq_divider #(.W(16)) u_div (
        .clk      (clk),
        .rst_n    (rstd_n),
        .start    (dv_start),
        .dividend (dv_a),
        .divisor  (dv_b),
        .done     (dv_done),
        .quot     (dv_q),
        .rem      (dv_r)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input int unsigned n);
        if (n < 2) return 1'b0;
        for (int unsigned k = 2; k * k <= n; k++)
            if (n % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Returns 0 when no prime above p fits below maxv.
    function automatic int unsigned next_prime(input int unsigned p, input int unsigned maxv);
        for (int unsigned c = p + 1; c <= maxv; c++)
            if (is_prime(c)) return c;
        return 0;
    endfunction

    task automatic run_div(input int unsigned a, input int unsigned b,
                           output int unsigned q, output int unsigned r, output int lat);
        @(negedge clk);
        dv_start = 1'b1;
        dv_a     = a[15:0];
        dv_b     = b[15:0];
        lat      = 0;
        do begin
            @(negedge clk);
            dv_start = 1'b0;
            lat++;
        end while (!dv_done && lat < 100);
        q = dv_q;
        r = dv_r;
    endtask

    task automatic pulse_go16();
        @(negedge clk);
        go16 = 1'b1;
        @(negedge clk);
        go16 = 1'b0;
    endtask

    task automatic wait_ready16(input int budget, output bit ok);
        int n = 0;
        while (!ready16 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = ready16;
    endtask

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned q;
        int unsigned r;
    } div_vec_t;

    div_vec_t    vecs[4];
    int unsigned exp_seq[10];
    int unsigned q, r, last, expv, cnt8, model_cnt, model_last;
    int          lat, cyc;
    bit          ok;

    initial begin
        vecs[0] = '{65535, 3, 21845, 0};
        vecs[1] = '{25, 5, 5, 0};
        vecs[2] = '{7, 3, 2, 1};
        vecs[3] = '{65521, 255, 256, 241};
        exp_seq = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31};

        rst16_n = 1'b0; rst8_n = 1'b0; rstd_n = 1'b0;
        go16 = 1'b0; go8 = 1'b1;
        dv_start = 1'b0; dv_a = '0; dv_b = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", ready16, 0);
        check("reset_error", error16, 0);
        check("reset_res", res16, 0);

        // Divider standalone
        rstd_n = 1'b1;
        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, q, r, lat);
            check("div_vec_q", q, vecs[i].q);
            check("div_vec_r", r, vecs[i].r);
            check("div_latency", lat, 16);
        end
        for (int i = 0; i < 8; i++) begin
            int unsigned a, b;
            a = $urandom_range(0, 65535);
            b = $urandom_range(3, 65535);
            run_div(a, b, q, r, lat);
            check("div_rand_q", q, a / b);
            check("div_rand_r", r, a % b);
        end

        // Start-up of the 16-bit stepper
        @(negedge clk);
        rst16_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("init_ready", ready16, 1);
        check("init_res", res16, 2);
        check("init_error", error16, 0);
        repeat (20) @(negedge clk);
        check("idle_hold_ready", ready16, 1);
        check("idle_hold_res", res16, 2);

        // Ten single-cycle requests
        for (int i = 0; i < 10; i++) begin
            pulse_go16();
            check("ready_drop", ready16, 0);
            wait_ready16(2000, ok);
            check("seq_timeout", ok, 1);
            check("seq_res", res16, exp_seq[i]);
        end

        // go while busy is ignored
        pulse_go16();
        repeat (3) @(negedge clk);
        check("busy_ready", ready16, 0);
        pulse_go16();
        wait_ready16(2000, ok);
        check("busy_timeout", ok, 1);
        check("busy_res", res16, next_prime(31, 65535));

        // Random go activity against the model
        last = res16;
        cnt8 = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ready16 && res16 != last) begin
                check("rand_res", res16, next_prime(last, 65535));
                last = res16;
                cnt8++;
            end
            go16 = 1'($urandom_range(0, 1));
        end
        go16 = 1'b0;
        check("rand_progress", cnt8 > 5, 1);
        check("rand_error", error16, 0);

        // Reset in the middle of testing candidate 9
        wait_ready16(2000, ok);
        @(negedge clk);
        rst16_n = 1'b0;
        @(negedge clk);
        rst16_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse_go16();
            wait_ready16(2000, ok);
        end
        check("pre_abort_res", res16, 7);
        pulse_go16();
        repeat (3) @(negedge clk);
        rst16_n = 1'b0;
        #1;
        check("abort_ready", ready16, 0);
        check("abort_error", error16, 0);
        check("abort_res", res16, 0);
        @(negedge clk);
        rst16_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("restart_res", res16, 2);
        check("restart_ready", ready16, 1);
        pulse_go16();
        wait_ready16(2000, ok);
        check("restart_next", res16, 3);

        // 8-bit instance, go tied high from reset, through to overflow
        model_cnt  = 0;
        model_last = 0;
        for (int unsigned n = 2; n <= 255; n++)
            if (is_prime(n)) begin
                model_cnt++;
                model_last = n;
            end
        @(negedge clk);
        rst8_n = 1'b1;
        last = 0;
        expv = 2;
        cnt8 = 0;
        cyc  = 0;
        while (!error8 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (ready8 && !error8 && res8 != last) begin
                check("sweep_res", res8, expv);
                last = res8;
                expv = next_prime(expv, 255);
                cnt8++;
            end
        end
        check("sweep_timeout", error8, 1);
        check("sweep_count", cnt8, model_cnt);
        check("sweep_model_end", expv, 0);
        check("ovf_res", res8, model_last);
        check("ovf_ready", ready8, 1);
        repeat (50) @(negedge clk);
        check("ovf_hold_res", res8, model_last);
        check("ovf_hold_error", error8, 1);
        check("ovf_hold_ready", ready8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
